// File: rtl/uart_tx_frame_ctrl_if.sv
// Signal bundle between a UART_TX frame source and uart_tx_frame_ctrl: parallel request,
// frame options, parity-calculator loop and the serial line with its Busy flag.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  par_bit;
    logic [DATA_WIDTH-1:0] lat_data;
    logic                  lat_par_typ;
    logic                  TX_OUT;
    logic                  Busy;

    // par_bit is produced by the external parity calculator; it sits on the master side
    // together with the other signals the controller consumes.
    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, par_bit,
        input  lat_data, lat_par_typ, TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, par_bit,
        output lat_data, lat_par_typ, TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: latches a byte, serialises START/DATA/[PARITY]/STOP at one bit
// per CLK. Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2).
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_tx_frame_ctrl_if.slave   bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [DATA_WIDTH-1:0] lat_data_q;
    logic                  lat_par_typ_q;
    logic                  lat_par_en_q;
    logic                  tx_d;
    logic                  busy_d;
    logic                  tx_q;
    logic                  busy_q;
    logic                  accept;

    assign accept = (state == IDLE) && bus.Data_Valid;

    // NOTE: registers take <= so every flop samples the pre-edge value of the others.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaults first in every always_comb; a path that leaves a signal unassigned infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.Data_Valid) next_state = START;
            START:   next_state = DATA;
            DATA:    if (cnt == CNT_LAST) next_state = lat_par_en_q ? PARITY : STOP;
            PARITY:  next_state = STOP;
`ifdef UART_TX_TWO_STOP_EN
            STOP:    next_state = STOP2;
            STOP2:   next_state = IDLE;
`else
            STOP:    next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so TX_OUT/Busy can be registered
    // without adding a cycle of latency behind the state register.
    always_comb begin
        cnt_next = '0;
        tx_d     = 1'b1;
        busy_d   = 1'b1;
        if (state == DATA && cnt != CNT_LAST) begin
            cnt_next = cnt + 1'b1;
        end
        case (next_state)
            IDLE:    busy_d = 1'b0;
            START:   tx_d   = 1'b0;
            DATA:    tx_d   = lat_data_q[cnt_next];
            PARITY:  tx_d   = bus.par_bit;
            STOP:    tx_d   = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
            STOP2:   tx_d   = 1'b1;
`endif
            default: busy_d = 1'b0;
        endcase
    end

    // Latched frame options stay put until the next acceptance so par_bit remains valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_data_q    <= '0;
            lat_par_typ_q <= 1'b0;
            lat_par_en_q  <= 1'b0;
            cnt           <= '0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            if (accept) begin
                lat_data_q    <= bus.P_DATA;
                lat_par_typ_q <= bus.PAR_TYP;
                lat_par_en_q  <= bus.PAR_EN;
            end
            cnt    <= cnt_next;
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

    assign bus.lat_data    = lat_data_q;
    assign bus.lat_par_typ = lat_par_typ_q;
    assign bus.TX_OUT      = tx_q;
    assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl: a frame-level model queues expected line cycles
// on acceptance; a negedge monitor compares every cycle against the queue or the idle line.
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int N_STOP = 2;
`else
    localparam int N_STOP = 1;
`endif

    typedef struct {
        logic          tx;
        logic [DW-1:0] data;
        logic          typ;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Parity calculator in the environment: even -> XOR of data, odd -> its inverse.
    assign bus.par_bit = (^bus.lat_data) ^ bus.lat_par_typ;

    always #5 CLK = ~CLK;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_free = 0;
    bit   mon_en = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic int frame_len(input logic en);
        return 1 + DW + int'(en) + N_STOP;
    endfunction

    task automatic push_frame(input logic [DW-1:0] d, input logic en, input logic typ);
        exp_q.push_back('{tx: 1'b0, data: d, typ: typ});
        for (int i = 0; i < DW; i++) exp_q.push_back('{tx: d[i], data: d, typ: typ});
        if (en) exp_q.push_back('{tx: (typ ? ~(^d) : (^d)), data: d, typ: typ});
        for (int i = 0; i < N_STOP; i++) exp_q.push_back('{tx: 1'b1, data: d, typ: typ});
    endtask

    // One bit period: present inputs, predict acceptance, cross the edge, then record the frame.
    task automatic step(input logic dv, input logic [DW-1:0] d, input logic en, input logic typ);
        bit acc;
        bus.Data_Valid = dv;
        bus.P_DATA     = d;
        bus.PAR_EN     = en;
        bus.PAR_TYP    = typ;
        acc = dv && !RST && (cyc + 1 >= next_free);
        if (acc) next_free = cyc + 1 + frame_len(en) + 1;
        @(posedge CLK);
        #1;
        cyc++;
        if (acc) push_frame(d, en, typ);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            step(1'b0, '0, 1'b0, 1'b0);
            budget++;
        end
        check(exp_q.size() == 0, "drain_timeout", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    always @(negedge CLK) begin
        if (mon_en && !RST) begin
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check({bus.Busy, bus.TX_OUT, bus.lat_par_typ, bus.lat_data} ==
                      {1'b1, e.tx, e.typ, e.data}, "frame_bit",
                      {21'd0, bus.Busy, bus.TX_OUT, bus.lat_par_typ, bus.lat_data},
                      {21'd0, 1'b1, e.tx, e.typ, e.data});
            end else begin
                check({bus.Busy, bus.TX_OUT} == 2'b01, "idle_line",
                      {30'd0, bus.Busy, bus.TX_OUT}, 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = '0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check({bus.Busy, bus.TX_OUT, bus.lat_par_typ, bus.lat_data} == {3'b010, 8'h00},
              "reset_state", {21'd0, bus.Busy, bus.TX_OUT, bus.lat_par_typ, bus.lat_data},
              32'h200);
        RST       = 1'b0;
        next_free = 0;
        mon_en    = 1'b1;
        idle(2);

        // Reset mid-DATA: outputs must return to idle before the next edge.
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        idle(4);
        #1;
        RST = 1'b1;
        #1;
        check({bus.Busy, bus.TX_OUT} == 2'b01, "async_reset_line",
              {30'd0, bus.Busy, bus.TX_OUT}, 32'd1);
        check({bus.lat_par_typ, bus.lat_data} == 9'd0, "async_reset_latch",
              {23'd0, bus.lat_par_typ, bus.lat_data}, 32'd0);
        exp_q.delete();
        idle(2);
        RST       = 1'b0;
        next_free = 0;
        idle(1);

        // Directed frames: even A5, odd 01, no-parity 3C.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        drain();
        step(1'b1, 8'h01, 1'b1, 1'b1);
        drain();
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        drain();

        // A request during DATA of another frame is dropped.
        step(1'b1, 8'h00, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        drain();

        // Data_Valid held high: repeated frames with one idle cycle between them.
        for (int i = 0; i < 40; i++) step(1'b1, 8'h55, 1'b1, 1'b0);
        drain();

        // Random traffic, including requests that land while the line is busy.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), DW'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
